tic_tac_toe_game: RTL and testbench
===================================

TIC_TAC_TOE_GAME -- requirements
Module: tic_tac_toe_game

Interface
REQ-001 The block SHALL have no parameters; board size (3x3) and all encodings are fixed.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high; clears board, winner and FSM.
REQ-005 play  input  1  level request: player places a mark at player_pos.
REQ-006 pc  input  1  level request: computer places a mark at com_position.
REQ-007 com_position  input  4  computer target cell index; 0..8 valid.
REQ-008 player_pos  input  4  player target cell index; 0..8 valid.
REQ-009 p1..p9  output  2 each  registered cell contents; index 0 maps to p1 and index 8 maps to p9, row-major (p1 p2 p3 / p4 p5 p6 / p7 p8 p9).
REQ-010 winner  output  2  game result: 00 none, 01 player, 10 computer, 11 draw.

Function
REQ-011 Cell encoding SHALL be: 00 empty, 01 player mark, 10 computer mark; 11 is never written.
REQ-012 The FSM SHALL have three states: PLAYER_TURN, COMPUTER_TURN and GAME_DONE.
REQ-013 In PLAYER_TURN, when play=1, player_pos<=8 and the target cell is 00, the block SHALL write 01 to that cell on the clock edge and move to COMPUTER_TURN.
REQ-014 In COMPUTER_TURN, when pc=1, com_position<=8 and the target cell is 00, the block SHALL write 10 to that cell on the clock edge and move to PLAYER_TURN.
REQ-015 An illegal request SHALL be ignored, with no board change and no state change; a request is illegal if the index is 9..15 or the target cell is occupied.
REQ-016 In PLAYER_TURN, pc SHALL be ignored; in COMPUTER_TURN, play SHALL be ignored; if both are high, only the input belonging to the current turn is honoured.
REQ-017 A request held high for multiple cycles SHALL produce exactly one move, because the turn changes after the first accepted move.
REQ-018 At most one cell SHALL change per clock.
REQ-019 winner SHALL be a combinational decode of the registered board, valid in the same cycle the board updates (zero added latency after the move edge).
REQ-020 Win lines SHALL be the 3 rows, 3 columns and 2 diagonals: (1,2,3) (4,5,6) (7,8,9) (1,4,7) (2,5,8) (3,6,9) (1,5,9) (3,5,7).
REQ-021 A line of three 01 cells SHALL give winner=01; a line of three 10 cells SHALL give winner=10.
REQ-022 If the board is full with no win line, winner SHALL be 11.
REQ-023 When an accepted move produces a nonzero winner, the FSM SHALL enter GAME_DONE on the next edge.
REQ-024 In GAME_DONE, the board and winner SHALL be frozen and all play/pc requests ignored until reset.
REQ-025 A win on the ninth move SHALL report 01 or 10, not 11; a win takes priority over a draw.
REQ-026 Both players winning at once is impossible under REQ-018; the decode SHALL still give priority to 01.

Reset
REQ-027 While reset=1 at a rising edge, p1..p9 SHALL become 00, winner SHALL be 00, the FSM SHALL enter PLAYER_TURN, and play/pc SHALL be ignored.
REQ-028 Reset SHALL take effect in any state, including mid-game and GAME_DONE.
REQ-029 No output SHALL change asynchronously.

Verification
REQ-030 Reset for 10 cycles, then release -> all p1..p9=00, winner=00.
REQ-031 Row win: play@0, pc@4, play@1, pc@8, play@2, each request held about 5 cycles, alternating -> p1=p2=p3=01, p5=p9=10, winner=01, then GAME_DONE.
REQ-032 Illegal moves: play@0 accepted; pc@0 (occupied) -> no change, still COMPUTER_TURN; pc@12 -> no change; pc@3 -> p4=10.
REQ-033 Turn order: in PLAYER_TURN drive pc=1 with com_position=5 -> p6 stays 00; play and pc high together -> only the player mark is written.
REQ-034 Draw: full board 01,10,01,01,10,10,10,01,01 (p1..p9) with legal alternating moves -> winner=11; a further play/pc changes nothing.
REQ-035 After a player win, hold play=1 and pc=1 -> board frozen; then assert reset for one cycle -> board cleared, winner=00, PLAYER_TURN.

Source files
------------

// File: rtl/tic_tac_toe_game.sv
// -----------------------------------------------------------------------------
// tic_tac_toe_game
//
// Two-party tic-tac-toe referee on a 3x3 board. The player and the computer
// take turns placing marks; illegal or out-of-turn requests are dropped. Once
// a win or a draw is on the board the game freezes until reset.
//
// Ports
//   clock         rising-edge clock for all state
//   reset         synchronous, active-high; clears board and returns to
//                 PLAYER_TURN
//   play          player move request (level)
//   pc            computer move request (level)
//   com_position  computer target cell, 0..8 (row-major)
//   player_pos    player target cell, 0..8 (row-major)
//   p1..p9        registered cell contents: 00 empty, 01 player, 10 computer
//   winner        combinational result: 00 none, 01 player, 10 computer,
//                 11 draw
//
// State          | meaning
// ---------------+------------------------------------------------------------
// PLAYER_TURN    | waiting for a legal player move
// COMPUTER_TURN  | waiting for a legal computer move
// GAME_DONE      | result on the board; everything frozen until reset
// -----------------------------------------------------------------------------
module tic_tac_toe_game (
    input  logic       clock,
    input  logic       reset,
    input  logic       play,
    input  logic       pc,
    input  logic [3:0] com_position,
    input  logic [3:0] player_pos,
    output logic [1:0] p1,
    output logic [1:0] p2,
    output logic [1:0] p3,
    output logic [1:0] p4,
    output logic [1:0] p5,
    output logic [1:0] p6,
    output logic [1:0] p7,
    output logic [1:0] p8,
    output logic [1:0] p9,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        PLAYER_TURN   = 2'b00,
        COMPUTER_TURN = 2'b01,
        GAME_DONE     = 2'b10
    } state_t;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_COMP   = 2'b10;

    state_t          state;
    state_t          state_next;
    logic [8:0][1:0] board;
    logic            wr_en;
    logic [3:0]      wr_idx;
    logic [1:0]      wr_val;
    logic            player_ok;
    logic            com_ok;
    logic            player_line;
    logic            com_line;
    logic            board_full;

    // Range check first so an out-of-range index never reads the board.
    function automatic logic cell_free(input logic [8:0][1:0] b,
                                       input logic [3:0]      idx);
        if (idx > 4'd8) begin
            return 1'b0;
        end
        return b[idx] == CELL_EMPTY;
    endfunction

    function automatic logic has_line(input logic [8:0][1:0] b,
                                      input logic [1:0]      mark);
        logic hit;
        hit = 1'b0;
        hit |= (b[0] == mark) && (b[1] == mark) && (b[2] == mark);
        hit |= (b[3] == mark) && (b[4] == mark) && (b[5] == mark);
        hit |= (b[6] == mark) && (b[7] == mark) && (b[8] == mark);
        hit |= (b[0] == mark) && (b[3] == mark) && (b[6] == mark);
        hit |= (b[1] == mark) && (b[4] == mark) && (b[7] == mark);
        hit |= (b[2] == mark) && (b[5] == mark) && (b[8] == mark);
        hit |= (b[0] == mark) && (b[4] == mark) && (b[8] == mark);
        hit |= (b[2] == mark) && (b[4] == mark) && (b[6] == mark);
        return hit;
    endfunction

    assign player_ok = cell_free(board, player_pos);
    assign com_ok    = cell_free(board, com_position);

    // Result decode straight off the board register; a win outranks a full
    // board, and a player line outranks a computer line.
    always_comb begin
        player_line = has_line(board, CELL_PLAYER);
        com_line    = has_line(board, CELL_COMP);
        board_full  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (board[i] == CELL_EMPTY) begin
                board_full = 1'b0;
            end
        end
        if (player_line) begin
            winner = 2'b01;
        end else if (com_line) begin
            winner = 2'b10;
        end else if (board_full) begin
            winner = 2'b11;
        end else begin
            winner = 2'b00;
        end
    end

    // A decided board diverts to GAME_DONE before any further move is taken,
    // so the turn that follows a winning move can never write a cell.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_idx     = 4'd0;
        wr_val     = CELL_EMPTY;
        case (state)
            PLAYER_TURN: begin
                if (winner != 2'b00) begin
                    state_next = GAME_DONE;
                end else if (play && player_ok) begin
                    wr_en      = 1'b1;
                    wr_idx     = player_pos;
                    wr_val     = CELL_PLAYER;
                    state_next = COMPUTER_TURN;
                end
            end
            COMPUTER_TURN: begin
                if (winner != 2'b00) begin
                    state_next = GAME_DONE;
                end else if (pc && com_ok) begin
                    wr_en      = 1'b1;
                    wr_idx     = com_position;
                    wr_val     = CELL_COMP;
                    state_next = PLAYER_TURN;
                end
            end
            GAME_DONE: begin
                state_next = GAME_DONE;
            end
            default: begin
                state_next = PLAYER_TURN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PLAYER_TURN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            board <= '0;
        end else if (wr_en) begin
            board[wr_idx] <= wr_val;
        end
    end

    assign p1 = board[0];
    assign p2 = board[1];
    assign p3 = board[2];
    assign p4 = board[3];
    assign p5 = board[4];
    assign p6 = board[5];
    assign p7 = board[6];
    assign p8 = board[7];
    assign p9 = board[8];

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// -----------------------------------------------------------------------------
// tb_tic_tac_toe_game
//
// Directed bench for tic_tac_toe_game. Stimulus tasks drive move requests and
// queue the hand-computed board/winner expected once the request is released;
// a separate monitor pops the queue shortly after each falling edge and
// compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_tic_tac_toe_game;

    typedef logic [8:0][1:0] board_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       play;
    logic       pc;
    logic [3:0] com_position;
    logic [3:0] player_pos;
    logic [1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic [1:0] winner;
    board_t     dut_board;

    int         tests_run = 0;
    int         tests_failed = 0;

    board_t     q_board[$];
    logic [1:0] q_winner[$];
    string      q_name[$];

    always #5 clock = ~clock;

    tic_tac_toe_game dut (
        .clock        (clock),
        .reset        (reset),
        .play         (play),
        .pc           (pc),
        .com_position (com_position),
        .player_pos   (player_pos),
        .p1           (p1),
        .p2           (p2),
        .p3           (p3),
        .p4           (p4),
        .p5           (p5),
        .p6           (p6),
        .p7           (p7),
        .p8           (p8),
        .p9           (p9),
        .winner       (winner)
    );

    assign dut_board = {p9, p8, p7, p6, p5, p4, p3, p2, p1};

    function automatic board_t b9(input int c1, input int c2, input int c3,
                                  input int c4, input int c5, input int c6,
                                  input int c7, input int c8, input int c9);
        board_t r;
        r[0] = c1[1:0]; r[1] = c2[1:0]; r[2] = c3[1:0];
        r[3] = c4[1:0]; r[4] = c5[1:0]; r[5] = c6[1:0];
        r[6] = c7[1:0]; r[7] = c8[1:0]; r[8] = c9[1:0];
        return r;
    endfunction

    task automatic expect_state(input board_t b, input logic [1:0] w,
                                input string name);
        q_board.push_back(b);
        q_winner.push_back(w);
        q_name.push_back(name);
    endtask

    // Inputs applied on a falling edge, held for cyc rising edges, then dropped.
    task automatic step(input logic pl, input logic [3:0] pp, input logic c,
                        input logic [3:0] cp, input int cyc);
        @(negedge clock);
        play = pl; player_pos = pp; pc = c; com_position = cp;
        repeat (cyc) @(negedge clock);
        play = 1'b0; pc = 1'b0;
    endtask

    task automatic mv_p(input logic [3:0] pos);
        step(1'b1, pos, 1'b0, 4'd0, 5);
    endtask

    task automatic mv_c(input logic [3:0] pos);
        step(1'b0, 4'd0, 1'b1, pos, 5);
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clock);
        reset = 1'b1;
        repeat (cyc) @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: the DUT presents a settled board after every falling edge.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            while (q_board.size() > 0) begin
                board_t     eb;
                logic [1:0] ew;
                string      en;
                eb = q_board.pop_front();
                ew = q_winner.pop_front();
                en = q_name.pop_front();
                tests_run++;
                if (dut_board !== eb) begin
                    tests_failed++;
                    $display("FAIL %s board: got %h required %h", en, dut_board, eb);
                end
                tests_run++;
                if (winner !== ew) begin
                    tests_failed++;
                    $display("FAIL %s winner: got %b required %b", en, winner, ew);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; play = 1'b0; pc = 1'b0;
        com_position = 4'd0; player_pos = 4'd0;

        // Reset for 10 cycles with a player request held; it must be ignored.
        @(negedge clock);
        play = 1'b1; player_pos = 4'd0;
        reset = 1'b1;
        repeat (10) @(negedge clock);
        reset = 1'b0; play = 1'b0;
        expect_state(b9(0,0,0,0,0,0,0,0,0), 2'b00, "reset");

        // Row win for the player.
        mv_p(4'd0); expect_state(b9(1,0,0,0,0,0,0,0,0), 2'b00, "row_m1");
        mv_c(4'd4); expect_state(b9(1,0,0,0,2,0,0,0,0), 2'b00, "row_m2");
        mv_p(4'd1); expect_state(b9(1,1,0,0,2,0,0,0,0), 2'b00, "row_m3");
        mv_c(4'd8); expect_state(b9(1,1,0,0,2,0,0,0,2), 2'b00, "row_m4");
        mv_p(4'd2); expect_state(b9(1,1,1,0,2,0,0,0,2), 2'b01, "row_win");
        step(1'b1, 4'd3, 1'b1, 4'd6, 6);
        expect_state(b9(1,1,1,0,2,0,0,0,2), 2'b01, "frozen");
        do_reset(1);
        expect_state(b9(0,0,0,0,0,0,0,0,0), 2'b00, "reset_after_win");
        mv_p(4'd4); expect_state(b9(0,0,0,0,1,0,0,0,0), 2'b00, "player_first");

        // Illegal moves.
        do_reset(2);
        mv_p(4'd0);  expect_state(b9(1,0,0,0,0,0,0,0,0), 2'b00, "ill_p0");
        mv_c(4'd0);  expect_state(b9(1,0,0,0,0,0,0,0,0), 2'b00, "ill_occupied");
        mv_c(4'd12); expect_state(b9(1,0,0,0,0,0,0,0,0), 2'b00, "ill_range");
        mv_p(4'd5);  expect_state(b9(1,0,0,0,0,0,0,0,0), 2'b00, "ill_turn");
        mv_c(4'd3);  expect_state(b9(1,0,0,2,0,0,0,0,0), 2'b00, "ill_c3");
        mv_p(4'd9);  expect_state(b9(1,0,0,2,0,0,0,0,0), 2'b00, "ill_p9");
        mv_p(4'd0);  expect_state(b9(1,0,0,2,0,0,0,0,0), 2'b00, "ill_p_occ");
        mv_p(4'd1);  expect_state(b9(1,1,0,2,0,0,0,0,0), 2'b00, "ill_p1");

        // Turn order.
        do_reset(1);
        mv_c(4'd5); expect_state(b9(0,0,0,0,0,0,0,0,0), 2'b00, "pc_in_player_turn");
        step(1'b1, 4'd1, 1'b1, 4'd2, 1);
        expect_state(b9(0,1,0,0,0,0,0,0,0), 2'b00, "both_high");
        mv_c(4'd2); expect_state(b9(0,1,2,0,0,0,0,0,0), 2'b00, "comp_after_both");

        // Draw.
        do_reset(1);
        mv_p(4'd0); mv_c(4'd1); mv_p(4'd2); mv_c(4'd4);
        mv_p(4'd3); mv_c(4'd5); mv_p(4'd7); mv_c(4'd6);
        expect_state(b9(1,2,1,1,2,2,2,1,0), 2'b00, "draw_m8");
        mv_p(4'd8);
        expect_state(b9(1,2,1,1,2,2,2,1,1), 2'b11, "draw");
        step(1'b1, 4'd8, 1'b1, 4'd0, 3);
        expect_state(b9(1,2,1,1,2,2,2,1,1), 2'b11, "draw_frozen");

        // Player win on the ninth move with a full board.
        do_reset(1);
        mv_p(4'd0); mv_c(4'd1); mv_p(4'd2); mv_c(4'd4);
        mv_p(4'd3); mv_c(4'd5); mv_p(4'd7); mv_c(4'd8);
        expect_state(b9(1,2,1,1,2,2,0,1,2), 2'b00, "ninth_m8");
        mv_p(4'd6);
        expect_state(b9(1,2,1,1,2,2,1,1,2), 2'b01, "ninth_win");

        // Computer diagonal win, then frozen.
        do_reset(1);
        mv_p(4'd0); mv_c(4'd4); mv_p(4'd1); mv_c(4'd2); mv_p(4'd5); mv_c(4'd6);
        expect_state(b9(1,1,2,0,2,1,2,0,0), 2'b10, "comp_win");
        mv_p(4'd3); mv_c(4'd7);
        expect_state(b9(1,1,2,0,2,1,2,0,0), 2'b10, "comp_frozen");

        repeat (4) @(negedge clock);
        #2;
        if (q_board.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending required 0", q_board.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
